booth_mult: RTL

Sequential signed 32×32 multiplier for the MIPS multicycle datapath, implementing radix-2 Booth over 32 iterations. It sits directly downstream of the control unit: it consumes `mult_ctrl` and the two register-file operands and returns `mult_end`. It also produces the 64-bit product that the HI/LO registers capture under `hi_ctrl`/`lo_ctrl` in the controller's MULT_2 step.

---
 rtl/booth_mult.sv | 116 +++++++++++
 1 files changed

// File: rtl/booth_mult.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier (one iteration per clock).
// Optional BOOTH_MULT_ZERO_SKIP_EN: a zero operand at acceptance bypasses RUN.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_end,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [WIDTH:0] acc, m, sum, acc_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic           q_m1;
    logic [CW-1:0]  count;
    logic           last_iter;

`ifdef BOOTH_MULT_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (a == '0) || (b == '0);
`endif

    assign last_iter = (count == LAST);

    // Booth step: add/subtract the sign-extended multiplicand, then arithmetic shift {acc,q,q_m1}
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt   = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mult_ctrl) begin
`ifdef BOOTH_MULT_ZERO_SKIP_EN
                    state_nxt = zero_op ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DONE);
        mult_end = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            m      <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_ctrl) begin
                        m     <= {a[WIDTH-1], a};
                        q     <= b;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        count <= '0;
`ifdef BOOTH_MULT_ZERO_SKIP_EN
                        if (zero_op) begin
                            hi_out <= '0;
                            lo_out <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    q     <= q_nxt;
                    q_m1  <= q[0];
                    count <= count + CW'(1);
                    // Result is captured on the edge that enters DONE
                    if (last_iter) begin
                        hi_out <= acc_nxt[WIDTH-1:0];
                        lo_out <= q_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
